disparity_search_ctrl: RTL

Sequencer for the stereo block-matching SSD datapath. For one left-image block it steps through candidate disparities d = 0 … MAX_DISP-1. For each candidate it:
- clears the SMAC accumulators,
- streams BLOCK row beats into the SSD datapath,
- waits for the datapath to drain, then samples the SSD.

It tracks the running minimum and reports the winning disparity. It sits between the frame-scan logic (which issues one start per block position) and the SSD block datapath plus its row buffers.

---
 rtl/disparity_search_ctrl.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/disparity_search_ctrl.sv
// Block-matching disparity search sequencer: for each candidate disparity it
// clears the SSD accumulators, streams BLOCK row beats, waits DRAIN cycles, then keeps the minimum SSD.
module disparity_search_ctrl #(
   parameter int MAX_DISP = 16,
   parameter int BLOCK    = 6,
   parameter int DRAIN    = 2,
   parameter int X_W      = 9,
   parameter int Y_W      = 9,
   parameter int SSD_W    = 23,
   parameter int D_W      = $clog2(MAX_DISP) + 1
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             start_in,
   input  logic [X_W-1:0]   left_x_in,
   input  logic [Y_W-1:0]   left_y_in,
   output logic             busy_out,
   output logic [X_W-1:0]   left_x_out,
   output logic [X_W-1:0]   right_x_out,
   output logic [Y_W-1:0]   y_out,
   output logic [2:0]       row_out,
   output logic             ssd_clear_out,
   output logic             ssd_valid_out,
   input  logic [SSD_W-1:0] ssd_in,
   output logic             done_out,
   output logic [D_W-1:0]   disparity_out,
   output logic [SSD_W-1:0] min_ssd_out
);

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_COMPARE, S_DONE
   } state_t;

   localparam int CNT_MAX = (BLOCK > DRAIN) ? BLOCK : DRAIN;
   localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] FEED_LAST  = CNT_W'(BLOCK - 1);
   localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN - 1);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [D_W-1:0]     d_q, d_d;
   logic [D_W-1:0]     last_d_q, last_d_d;
   logic [X_W-1:0]     x_q, x_d;
   logic [Y_W-1:0]     y_q, y_d;
   logic [D_W-1:0]     best_d_q, best_d_d;
   logic [SSD_W-1:0]   best_ssd_q, best_ssd_d;

   logic               busy_q, busy_d;
   logic               clr_q, clr_d;
   logic               vld_q, vld_d;
   logic               done_q, done_d;
   logic [2:0]         row_q, row_d;
   logic [X_W-1:0]     lx_q, lx_d;
   logic [X_W-1:0]     rx_q, rx_d;
   logic [Y_W-1:0]     yo_q, yo_d;
   logic [D_W-1:0]     disp_q, disp_d;
   logic [SSD_W-1:0]   min_q, min_d;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      d_d        = d_q;
      last_d_d   = last_d_q;
      x_d        = x_q;
      y_d        = y_q;
      best_d_d   = best_d_q;
      best_ssd_d = best_ssd_q;
      disp_d     = disp_q;
      min_d      = min_q;

      unique case (state_q)
         S_IDLE: begin
            if (start_in) begin
               x_d   = left_x_in;
               y_d   = left_y_in;
               d_d   = '0;
               cnt_d = '0;
               // Truncate the search at the left image edge so right_x never goes negative.
               if (int'(left_x_in) >= MAX_DISP - 1) last_d_d = D_W'(MAX_DISP - 1);
               else                                 last_d_d = D_W'(left_x_in);
               state_d = S_CLEAR;
            end
         end
         S_CLEAR: begin
            cnt_d   = '0;
            state_d = S_FEED;
         end
         S_FEED: begin
            if (cnt_q == FEED_LAST) begin
               cnt_d   = '0;
               state_d = (DRAIN == 0) ? S_COMPARE : S_DRAIN;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DRAIN: begin
            if (cnt_q == DRAIN_LAST) begin
               cnt_d   = '0;
               state_d = S_COMPARE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_COMPARE: begin
            if (d_q == '0 || ssd_in < best_ssd_q) begin
               best_d_d   = d_q;
               best_ssd_d = ssd_in;
            end
            if (d_q == last_d_q) begin
               disp_d  = best_d_d;
               min_d   = best_ssd_d;
               state_d = S_DONE;
            end else begin
               d_d     = d_q + D_W'(1);
               state_d = S_CLEAR;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Outputs are decoded from the next state so they are registered yet line up with the state.
      busy_d = (state_d != S_IDLE);
      clr_d  = (state_d == S_CLEAR);
      vld_d  = (state_d == S_FEED);
      done_d = (state_d == S_DONE);
      row_d  = (state_d == S_FEED) ? 3'(cnt_d) : 3'd0;
      yo_d   = y_d + Y_W'(row_d);
      lx_d   = x_d;
      rx_d   = x_d - X_W'(d_d);
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         d_q        <= '0;
         last_d_q   <= '0;
         x_q        <= '0;
         y_q        <= '0;
         best_d_q   <= '0;
         best_ssd_q <= '0;
         busy_q     <= 1'b0;
         clr_q      <= 1'b0;
         vld_q      <= 1'b0;
         done_q     <= 1'b0;
         row_q      <= '0;
         lx_q       <= '0;
         rx_q       <= '0;
         yo_q       <= '0;
         disp_q     <= '0;
         min_q      <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         d_q        <= d_d;
         last_d_q   <= last_d_d;
         x_q        <= x_d;
         y_q        <= y_d;
         best_d_q   <= best_d_d;
         best_ssd_q <= best_ssd_d;
         busy_q     <= busy_d;
         clr_q      <= clr_d;
         vld_q      <= vld_d;
         done_q     <= done_d;
         row_q      <= row_d;
         lx_q       <= lx_d;
         rx_q       <= rx_d;
         yo_q       <= yo_d;
         disp_q     <= disp_d;
         min_q      <= min_d;
      end
   end

   assign busy_out      = busy_q;
   assign ssd_clear_out = clr_q;
   assign ssd_valid_out = vld_q;
   assign done_out      = done_q;
   assign row_out       = row_q;
   assign left_x_out    = lx_q;
   assign right_x_out   = rx_q;
   assign y_out         = yo_q;
   assign disparity_out = disp_q;
   assign min_ssd_out   = min_q;

endmodule
